// File: rtl/knn_topk_sort_if.sv
// knn_topk_sort_if
//   Candidate stream carried from the distance datapath into knn_topk_sort.
//   master : upstream distance stage (drives in_valid/in_dist/in_label)
//   slave  : knn_topk_sort (drives in_ready)
//   in_valid  - a (distance, label) pair is offered
//   in_dist   - candidate distance, unsigned, DIST_W bits
//   in_label  - candidate label, LABEL_W bits
//   in_ready  - the sorter can take the pair this cycle
interface knn_topk_sort_if #(
  parameter int DIST_W  = 32,
  parameter int LABEL_W = 8
);
  logic               in_valid;
  logic [DIST_W-1:0]  in_dist;
  logic [LABEL_W-1:0] in_label;
  logic               in_ready;

  modport master (output in_valid, output in_dist, output in_label, input in_ready);
  modport slave  (input in_valid, input in_dist, input in_label, output in_ready);
endinterface

// File: rtl/knn_topk_sort.sv
// knn_topk_sort
//   Keeps the K smallest (distance, label) pairs seen so far, sorted nearest
//   first, with an optional majority-vote engine over the kept labels.
//   Optional feature macro: KNN_VOTE_EN (vote engine present when defined).
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   clear             - pulse: empty the list and abort any insert/vote
//   in_if (slave)     - candidate stream (in_valid/in_dist/in_label/in_ready)
//   count             - number of valid entries, saturates at K
//   rd_idx            - read index, 0 = nearest
//   rd_dist/rd_label  - entry rd_idx (combinational); empty slots read all-ones/0
//   vote_start        - pulse: start a majority vote (ignored without KNN_VOTE_EN)
//   vote_busy         - vote in progress
//   vote_done         - one-cycle pulse, vote_label valid
//   vote_label        - winning label, held until the next vote or clear
module knn_topk_sort #(
  parameter int K       = 4,
  parameter int DIST_W  = 32,
  parameter int LABEL_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  knn_topk_sort_if.slave           in_if,
  output logic [$clog2(K+1)-1:0]   count,
  input  logic [$clog2(K)-1:0]     rd_idx,
  output logic [DIST_W-1:0]        rd_dist,
  output logic [LABEL_W-1:0]       rd_label,
  input  logic                     vote_start,
  output logic                     vote_busy,
  output logic                     vote_done,
  output logic [LABEL_W-1:0]       vote_label
);
  localparam int CNT_W = $clog2(K + 1);
  localparam int IDX_W = $clog2(K);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    INSERT = 2'd1
`ifdef KNN_VOTE_EN
    , VOTE = 2'd2
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [DIST_W-1:0]  dist_q  [K];
  logic [DIST_W-1:0]  dist_d  [K];
  logic [LABEL_W-1:0] label_q [K];
  logic [LABEL_W-1:0] label_d [K];
  logic [K-1:0]       valid_q, valid_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DIST_W-1:0]  pend_dist_q, pend_dist_d;
  logic [LABEL_W-1:0] pend_label_q, pend_label_d;

  logic [K-1:0]       hit_s;
  logic [IDX_W-1:0]   pos_s;
  logic               found_s;
  logic               in_ready_s;
  logic               accept_s;
  logic               rd_hit_s;

`ifdef KNN_VOTE_EN
  logic [IDX_W-1:0]   vidx_q, vidx_d;
  logic [LABEL_W-1:0] best_q, best_d;
  logic [CNT_W-1:0]   best_occ_q, best_occ_d;
  logic               vote_busy_q, vote_busy_d;
  logic               vote_done_q, vote_done_d;
  logic [LABEL_W-1:0] vote_label_q, vote_label_d;
  logic [CNT_W-1:0]   occ_s;
  logic [LABEL_W-1:0] cand_best_s;
  logic [CNT_W-1:0]   cand_occ_s;

  assign in_ready_s = (state_q == IDLE) && !rst && !clear && !vote_start;
  assign vote_busy  = vote_busy_q;
  assign vote_done  = vote_done_q;
  assign vote_label = vote_label_q;
`else
  logic unused_vote_start_s;

  assign unused_vote_start_s = vote_start;
  assign in_ready_s = (state_q == IDLE) && !rst && !clear;
  assign vote_busy  = 1'b0;
  assign vote_done  = 1'b0;
  assign vote_label = '0;
`endif

  assign in_if.in_ready = in_ready_s;
  assign accept_s       = in_if.in_valid && in_ready_s;
  assign count          = count_q;

  // Read port: slots at or beyond count always read as empty.
  assign rd_hit_s = (CNT_W'(rd_idx) < count_q);
  assign rd_dist  = rd_hit_s ? dist_q[rd_idx]  : '1;
  assign rd_label = rd_hit_s ? label_q[rd_idx] : '0;

  // Insert position: lowest slot that is empty or strictly farther than the
  // pending pair; strict compare keeps equal distances behind older entries.
  always_comb begin
    hit_s = '0;
    pos_s = '0;
    for (int i = 0; i < K; i++) begin
      hit_s[i] = !valid_q[i] || (pend_dist_q < dist_q[i]);
    end
    for (int i = K - 1; i >= 0; i--) begin
      pos_s = hit_s[i] ? IDX_W'(i) : pos_s;
    end
  end

  assign found_s = |hit_s;

`ifdef KNN_VOTE_EN
  // Vote candidate: occurrences of label[vidx] among valid entries, and the
  // running best after considering it (strict > so nearer labels win ties).
  always_comb begin
    occ_s = '0;
    for (int j = 0; j < K; j++) begin
      occ_s = occ_s + CNT_W'(valid_q[j] && (label_q[j] == label_q[vidx_q]));
    end
    if (occ_s > best_occ_q) begin
      cand_best_s = label_q[vidx_q];
      cand_occ_s  = occ_s;
    end else begin
      cand_best_s = best_q;
      cand_occ_s  = best_occ_q;
    end
  end
`endif

  // Next-state logic for the list, the pending pair and the vote engine.
  always_comb begin
    state_d      = state_q;
    dist_d       = dist_q;
    label_d      = label_q;
    valid_d      = valid_q;
    count_d      = count_q;
    pend_dist_d  = pend_dist_q;
    pend_label_d = pend_label_q;
`ifdef KNN_VOTE_EN
    vidx_d       = vidx_q;
    best_d       = best_q;
    best_occ_d   = best_occ_q;
    vote_busy_d  = vote_busy_q;
    vote_done_d  = 1'b0;
    vote_label_d = vote_label_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          pend_dist_d  = in_if.in_dist;
          pend_label_d = in_if.in_label;
          state_d      = INSERT;
        end
`ifdef KNN_VOTE_EN
        else if (vote_start) begin
          if (count_q == '0) begin
            // Empty list: answer immediately with label 0.
            vote_done_d  = 1'b1;
            vote_label_d = '0;
          end else begin
            state_d     = VOTE;
            vote_busy_d = 1'b1;
            vidx_d      = '0;
            best_d      = '0;
            best_occ_d  = '0;
          end
        end
`endif
        else begin
          state_d = IDLE;
        end
      end
      INSERT: begin
        if (found_s) begin
          for (int i = 1; i < K; i++) begin
            if (i > int'(pos_s)) begin
              dist_d[i]  = dist_q[i-1];
              label_d[i] = label_q[i-1];
              valid_d[i] = valid_q[i-1];
            end else begin
              dist_d[i]  = dist_q[i];
              label_d[i] = label_q[i];
              valid_d[i] = valid_q[i];
            end
          end
          dist_d[pos_s]  = pend_dist_q;
          label_d[pos_s] = pend_label_q;
          valid_d[pos_s] = 1'b1;
          count_d = (count_q < CNT_W'(K)) ? (count_q + CNT_W'(1)) : count_q;
        end else begin
          count_d = count_q;
        end
        state_d = IDLE;
      end
`ifdef KNN_VOTE_EN
      VOTE: begin
        best_d     = cand_best_s;
        best_occ_d = cand_occ_s;
        if (CNT_W'(vidx_q) == (count_q - CNT_W'(1))) begin
          vote_label_d = cand_best_s;
          vote_done_d  = 1'b1;
          vote_busy_d  = 1'b0;
          state_d      = IDLE;
        end else begin
          vidx_d = vidx_q + IDX_W'(1);
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; clear returns everything to the reset image.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q <= IDLE;
      for (int i = 0; i < K; i++) begin
        dist_q[i]  <= '1;
        label_q[i] <= '0;
      end
      valid_q      <= '0;
      count_q      <= '0;
      pend_dist_q  <= '0;
      pend_label_q <= '0;
`ifdef KNN_VOTE_EN
      vidx_q       <= '0;
      best_q       <= '0;
      best_occ_q   <= '0;
      vote_busy_q  <= 1'b0;
      vote_done_q  <= 1'b0;
      vote_label_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      dist_q       <= dist_d;
      label_q      <= label_d;
      valid_q      <= valid_d;
      count_q      <= count_d;
      pend_dist_q  <= pend_dist_d;
      pend_label_q <= pend_label_d;
`ifdef KNN_VOTE_EN
      vidx_q       <= vidx_d;
      best_q       <= best_d;
      best_occ_q   <= best_occ_d;
      vote_busy_q  <= vote_busy_d;
      vote_done_q  <= vote_done_d;
      vote_label_q <= vote_label_d;
`endif
    end
  end
endmodule

// File: tb/tb_knn_topk_sort.sv
// tb_knn_topk_sort
//   Directed bench for knn_topk_sort (K=4): reset image, sorting, ties,
//   rejection, clear abort and, when KNN_VOTE_EN is defined, the vote engine.
module tb_knn_topk_sort;
  localparam int K       = 4;
  localparam int DIST_W  = 32;
  localparam int LABEL_W = 8;
  localparam logic [31:0] EMPTY = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        vote_start;
  logic [2:0]  count;
  logic [1:0]  rd_idx;
  logic [31:0] rd_dist;
  logic [7:0]  rd_label;
  logic        vote_busy;
  logic        vote_done;
  logic [7:0]  vote_label;

  int tests = 0;
  int fails = 0;

  knn_topk_sort_if #(.DIST_W(DIST_W), .LABEL_W(LABEL_W)) in_if ();

  knn_topk_sort #(.K(K), .DIST_W(DIST_W), .LABEL_W(LABEL_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .in_if      (in_if),
    .count      (count),
    .rd_idx     (rd_idx),
    .rd_dist    (rd_dist),
    .rd_label   (rd_label),
    .vote_start (vote_start),
    .vote_busy  (vote_busy),
    .vote_done  (vote_done),
    .vote_label (vote_label)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_entry(input string tag, input int idx, input logic [31:0] d, input logic [7:0] l);
    rd_idx = 2'(idx);
    #1;
    chk($sformatf("%s_dist%0d", tag, idx), rd_dist, d);
    chk($sformatf("%s_label%0d", tag, idx), 32'(rd_label), 32'(l));
  endtask

  task automatic chk_empty(input string tag);
    for (int i = 0; i < K; i++) begin
      chk_entry(tag, i, EMPTY, 8'd0);
    end
  endtask

  // Offer one pair, check the handshake and the one-cycle ready gap.
  task automatic send(input string tag, input logic [31:0] d, input logic [7:0] l);
    int n;
    n = 0;
    in_if.in_valid = 1'b1;
    in_if.in_dist  = d;
    in_if.in_label = l;
    #1;
    while (in_if.in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_ready"}, 32'(in_if.in_ready), 32'd1);
    tick();
    in_if.in_valid = 1'b0;
    chk({tag, "_gap"}, 32'(in_if.in_ready), 32'd0);
    tick();
    chk({tag, "_back"}, 32'(in_if.in_ready), 32'd1);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    #1;
    chk("clear_blocks_ready", 32'(in_if.in_ready), 32'd0);
    tick();
    clear = 1'b0;
    #1;
  endtask

`ifdef KNN_VOTE_EN
  // Pulse vote_start and return the number of cycles until vote_done.
  task automatic run_vote(output int n);
    vote_start = 1'b1;
    tick();
    vote_start = 1'b0;
    n = 1;
    while (vote_done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask
`endif

  initial begin
    int n;
    rst = 1'b1;
    clear = 1'b0;
    vote_start = 1'b0;
    rd_idx = 2'd0;
    in_if.in_valid = 1'b0;
    in_if.in_dist  = 32'd0;
    in_if.in_label = 8'd0;
    tick();
    chk("ready_in_reset", 32'(in_if.in_ready), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_ready", 32'(in_if.in_ready), 32'd1);
    chk("reset_vote_busy", 32'(vote_busy), 32'd0);
    chk("reset_vote_done", 32'(vote_done), 32'd0);
    chk("reset_vote_label", 32'(vote_label), 32'd0);
    chk_empty("reset");

    // Sorting with drops of 80 and 90.
    send("s50", 32'd50, 8'd1);
    chk("cnt_after_1", 32'(count), 32'd1);
    chk_entry("one", 0, 32'd50, 8'd1);
    chk_entry("one", 1, EMPTY, 8'd0);
    send("s20", 32'd20, 8'd2);
    chk_entry("two", 0, 32'd20, 8'd2);
    chk_entry("two", 1, 32'd50, 8'd1);
    send("s80", 32'd80, 8'd3);
    send("s10", 32'd10, 8'd4);
    send("s30", 32'd30, 8'd5);
    send("s90", 32'd90, 8'd6);
    chk("sort_count", 32'(count), 32'd4);
    chk_entry("sort", 0, 32'd10, 8'd4);
    chk_entry("sort", 1, 32'd20, 8'd2);
    chk_entry("sort", 2, 32'd30, 8'd5);
    chk_entry("sort", 3, 32'd50, 8'd1);

    // Equal distance goes behind the existing entry; equal to last is rejected.
    send("tie20", 32'd20, 8'd7);
    chk_entry("tie", 0, 32'd10, 8'd4);
    chk_entry("tie", 1, 32'd20, 8'd2);
    chk_entry("tie", 2, 32'd20, 8'd7);
    chk_entry("tie", 3, 32'd30, 8'd5);
    send("rej30", 32'd30, 8'd8);
    chk("rej_count", 32'(count), 32'd4);
    chk_entry("rej", 2, 32'd20, 8'd7);
    chk_entry("rej", 3, 32'd30, 8'd5);

    // Clear aborting an INSERT on a full list.
    in_if.in_valid = 1'b1;
    in_if.in_dist  = 32'd5;
    in_if.in_label = 8'd9;
    #1;
    chk("clr_ready", 32'(in_if.in_ready), 32'd1);
    tick();
    in_if.in_valid = 1'b0;
    do_clear();
    chk("clr_count", 32'(count), 32'd0);
    chk_empty("clr");
    tick();
    chk("clr_count_later", 32'(count), 32'd0);
    chk_entry("clr_later", 0, EMPTY, 8'd0);

    // All-ones distance is still inserted while not full; 0 goes in front.
    send("ones", EMPTY, 8'd3);
    chk("ones_count", 32'(count), 32'd1);
    chk_entry("ones", 0, EMPTY, 8'd3);
    send("zero", 32'd0, 8'd1);
    chk_entry("zero", 0, 32'd0, 8'd1);
    chk_entry("zero", 1, EMPTY, 8'd3);
    chk_entry("zero", 2, EMPTY, 8'd0);
    chk("zero_count", 32'(count), 32'd2);
    do_clear();

`ifdef KNN_VOTE_EN
    // Labels 2,3,3,2: tie between 2 and 3 goes to the nearer label 2.
    send("v_a0", 32'd10, 8'd2);
    send("v_a1", 32'd20, 8'd3);
    send("v_a2", 32'd30, 8'd3);
    send("v_a3", 32'd40, 8'd2);
    vote_start = 1'b1;
    #1;
    chk("vote_start_blocks_ready", 32'(in_if.in_ready), 32'd0);
    tick();
    vote_start = 1'b0;
    chk("vote_busy_a", 32'(vote_busy), 32'd1);
    n = 1;
    while (vote_done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("vote_latency_a", 32'(n), 32'd5);
    chk("vote_label_a", 32'(vote_label), 32'd2);
    chk("vote_busy_end_a", 32'(vote_busy), 32'd0);
    tick();
    chk("vote_done_pulse", 32'(vote_done), 32'd0);
    chk("vote_label_held", 32'(vote_label), 32'd2);
    do_clear();
    chk("vote_label_cleared", 32'(vote_label), 32'd0);

    // Labels 1,3,3,2: majority label 3.
    send("v_b0", 32'd10, 8'd1);
    send("v_b1", 32'd20, 8'd3);
    send("v_b2", 32'd30, 8'd3);
    send("v_b3", 32'd40, 8'd2);
    run_vote(n);
    chk("vote_latency_b", 32'(n), 32'd5);
    chk("vote_label_b", 32'(vote_label), 32'd3);

    // Collision: vote wins, pair waits and lands right after vote_done.
    in_if.in_valid = 1'b1;
    in_if.in_dist  = 32'd5;
    in_if.in_label = 8'd9;
    vote_start = 1'b1;
    #1;
    chk("col_ready_start", 32'(in_if.in_ready), 32'd0);
    tick();
    vote_start = 1'b0;
    n = 1;
    while (vote_done !== 1'b1 && n < 20) begin
      chk($sformatf("col_ready_busy%0d", n), 32'(in_if.in_ready), 32'd0);
      tick();
      n++;
    end
    chk("col_latency", 32'(n), 32'd5);
    chk("col_vote_label", 32'(vote_label), 32'd3);
    chk("col_ready_after", 32'(in_if.in_ready), 32'd1);
    tick();
    in_if.in_valid = 1'b0;
    chk("col_gap", 32'(in_if.in_ready), 32'd0);
    tick();
    chk("col_count", 32'(count), 32'd4);
    chk_entry("col", 0, 32'd5, 8'd9);
    chk_entry("col", 1, 32'd10, 8'd1);
    chk_entry("col", 3, 32'd30, 8'd3);

    // Empty list: vote_done the very next cycle with label 0.
    do_clear();
    run_vote(n);
    chk("vote_empty_latency", 32'(n), 32'd1);
    chk("vote_empty_label", 32'(vote_label), 32'd0);
    chk("vote_empty_busy", 32'(vote_busy), 32'd0);
`else
    // Without the vote engine, vote_start has no effect on the vote outputs.
    send("nv0", 32'd10, 8'd2);
    vote_start = 1'b1;
    tick();
    vote_start = 1'b0;
    chk("novote_busy", 32'(vote_busy), 32'd0);
    chk("novote_done", 32'(vote_done), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("novote_done%0d", i), 32'(vote_done), 32'd0);
    end
    chk("novote_label", 32'(vote_label), 32'd0);
    chk("novote_count", 32'(count), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/knn_topk_sort.md
Name: knn_topk_sort

Overview:
- Downstream stage of the KNN distance datapath inside iob_knn.
- Consumes a stream of (distance, label) pairs, one per training point, and maintains a sorted list of the K smallest distances with their labels.
- List contents are readable by index for the peripheral's register file.
- Optional majority-vote engine produces the classified label.

Parameters:
K, 4, number of nearest neighbours kept (2..16)
DIST_W, 32, distance width, unsigned
LABEL_W, 8, label width

Ports:
clk  in  1  system clock
rst  in  1  reset
clear  in  1  pulse: empty list, abort any operation
in_valid  in  1  input pair offered
in_dist  in  DIST_W  candidate distance, unsigned
in_label  in  LABEL_W  candidate label
in_ready  out  1  block can accept a pair this cycle
count  out  $clog2(K+1)  number of valid entries, saturates at K
rd_idx  in  $clog2(K)  read index, 0 = nearest
rd_dist  out  DIST_W  distance of entry rd_idx (combinational)
rd_label  out  LABEL_W  label of entry rd_idx (combinational)
vote_start  in  1  pulse: start majority vote (KNN_VOTE_EN only)
vote_busy  out  1  vote in progress
vote_done  out  1  one-cycle pulse, vote_label valid
vote_label  out  LABEL_W  winning label, held until next vote/clear

Behaviour:
- Reset: synchronous, active-high on rst, clock clk; all internal state updates on the rising edge of clk.
- Reset and clear values: entry dist = all-ones, entry label = 0, all entry valid bits = 0, count = 0, vote_busy = 0, vote_done = 0, vote_label = 0, state = IDLE. in_ready = 0 while rst is high.
- States: IDLE, INSERT, VOTE.
- in_ready = (state == IDLE) && !clear && !vote_start.
- Handshake: a transfer occurs on the cycle in_valid && in_ready. The pair is registered and state goes to INSERT.
- INSERT, one cycle:
  - Position p = lowest i where !valid[i] or in_dist < dist[i].
  - Entries p..K-2 shift to p+1. The entry at K-1 drops out. The new pair is written at p.
  - If no such p exists (list full and in_dist >= dist[K-1]), the pair is discarded with no change.
  - count increments only if it is < K. Return to IDLE.
- Throughput: one pair per 2 cycles. A new transfer is visible on rd_* and count 2 cycles after the handshake cycle.
- Ties are stable: an equal distance is placed after existing entries, so the earlier-arriving point wins.
- Distances compare as unsigned. An all-ones in_dist is still inserted when the list is not full.
- rd_idx >= count returns dist all-ones and label 0.
- clear has priority over everything: it acts on the next edge from any state and aborts INSERT or VOTE. The aborted pair is lost and no vote_done is produced.
- in_valid during INSERT or VOTE is held off (in_ready = 0). The upstream stage must keep its data stable until accepted.
- vote_start is ignored unless state == IDLE. In IDLE, vote_start has priority over a simultaneous in_valid.

Optional Feature:
- Macro: KNN_VOTE_EN.
- Defined:
  - vote_start in IDLE enters VOTE; vote_busy = 1. The engine iterates i = 0..count-1, one cycle per index.
  - Each cycle it computes occ = number of valid entries with label == label[i], using a combinational compare and popcount.
  - best is updated only when occ > best_occ (strict), so ties resolve to the label of the nearer neighbour.
  - After index count-1: vote_label = best, vote_done pulses 1 cycle, vote_busy = 0, return to IDLE.
  - Latency: count+1 cycles from the vote_start edge to vote_done.
  - count = 0: vote_done pulses the following cycle with vote_label = 0.
- Undefined: VOTE state and vote logic are absent. vote_start is ignored; vote_busy, vote_done and vote_label are tied to 0.

Test Plan:
- Reset check: after reset, count = 0, in_ready = 1, every rd_idx reads (all-ones, 0).
- K=4 sort: stream dist/label 50/1, 20/2, 80/3, 10/4, 30/5, 90/6 -> list 10/4, 20/2, 30/5, 50/1; count = 4; 80 and 90 dropped; in_ready low exactly one cycle after each accept.
- Ties and reject: on a list of 10/4, 20/2, 30/5, 50/1, send 20/7 -> list 10/4, 20/2, 20/7, 30/5. Then send 30/8 -> list unchanged.
- Clear during INSERT: accept 5/9, assert clear the next cycle -> count = 0, all entries empty, 5/9 not present.
- Vote (KNN_VOTE_EN): list labels 2, 3, 3, 2 (nearest first) -> vote_label = 2 (tie goes to nearer), vote_done 5 cycles after vote_start. Labels 1, 3, 3, 2 -> vote_label = 3.
- Vote/insert collision: vote_start and in_valid in the same IDLE cycle -> vote runs, in_ready = 0 throughout, the pair is accepted the first cycle after vote_done.
